// File: rtl/vga_controller_pkg.sv
// Shared 640x480 VGA timing constants, counter width and a window-decode helper.
package vga_controller_pkg;

    localparam int unsigned H_SYNC  = 96;
    localparam int unsigned H_BACK  = 48;
    localparam int unsigned H_DISP  = 640;
    localparam int unsigned H_FRONT = 16;

    localparam int unsigned V_SYNC  = 2;
    localparam int unsigned V_BACK  = 29;
    localparam int unsigned V_DISP  = 480;
    localparam int unsigned V_FRONT = 10;

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

    localparam int unsigned CNT_W = 10;

    typedef logic [CNT_W-1:0] cnt_t;

    // Half-open window test: lo <= v < hi.
    function automatic logic in_window(input cnt_t v, input cnt_t lo, input cnt_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Pixel-enable divider plus horizontal/vertical position counters.
module vga_timing_counter #(
    parameter int unsigned H_SYNC  = vga_controller_pkg::H_SYNC,
    parameter int unsigned H_BACK  = vga_controller_pkg::H_BACK,
    parameter int unsigned H_DISP  = vga_controller_pkg::H_DISP,
    parameter int unsigned H_FRONT = vga_controller_pkg::H_FRONT,
    parameter int unsigned V_SYNC  = vga_controller_pkg::V_SYNC,
    parameter int unsigned V_BACK  = vga_controller_pkg::V_BACK,
    parameter int unsigned V_DISP  = vga_controller_pkg::V_DISP,
    parameter int unsigned V_FRONT = vga_controller_pkg::V_FRONT
) (
    input  logic                     clk,
    input  logic                     rst,
    output vga_controller_pkg::cnt_t x,
    output vga_controller_pkg::cnt_t y,
    output logic                     visible
);
    import vga_controller_pkg::*;

    localparam cnt_t X_LAST    = cnt_t'(H_SYNC + H_BACK + H_DISP + H_FRONT - 1);
    localparam cnt_t Y_LAST    = cnt_t'(V_SYNC + V_BACK + V_DISP + V_FRONT - 1);
    localparam cnt_t X_DISP_LO = cnt_t'(H_SYNC + H_BACK);
    localparam cnt_t X_DISP_HI = cnt_t'(H_SYNC + H_BACK + H_DISP);
    localparam cnt_t Y_DISP_LO = cnt_t'(V_SYNC + V_BACK);
    localparam cnt_t Y_DISP_HI = cnt_t'(V_SYNC + V_BACK + V_DISP);

    logic pix_en_q, pix_en_d;
    cnt_t x_q, x_d;
    cnt_t y_q, y_d;

    // pix_en resets high so the very first edge after release advances x.
    always_comb begin
        pix_en_d = ~pix_en_q;
        x_d      = x_q;
        y_d      = y_q;
        if (pix_en_q) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_en_q <= 1'b1;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            pix_en_q <= pix_en_d;
            x_q      <= x_d;
            y_q      <= y_d;
        end
    end

    assign x       = x_q;
    assign y       = y_q;
    assign visible = in_window(x_q, X_DISP_LO, X_DISP_HI)
                  && in_window(y_q, Y_DISP_LO, Y_DISP_HI);

endmodule

// File: rtl/vga_controller.sv
// 640x480 VGA driver: sync pulses and a column-band colour test pattern.
module vga_controller #(
    parameter int unsigned H_SYNC  = vga_controller_pkg::H_SYNC,
    parameter int unsigned H_BACK  = vga_controller_pkg::H_BACK,
    parameter int unsigned H_DISP  = vga_controller_pkg::H_DISP,
    parameter int unsigned H_FRONT = vga_controller_pkg::H_FRONT,
    parameter int unsigned V_SYNC  = vga_controller_pkg::V_SYNC,
    parameter int unsigned V_BACK  = vga_controller_pkg::V_BACK,
    parameter int unsigned V_DISP  = vga_controller_pkg::V_DISP,
    parameter int unsigned V_FRONT = vga_controller_pkg::V_FRONT
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] color,
    output logic       vSync,
    output logic       hSync
);
    import vga_controller_pkg::*;

    localparam cnt_t X_SYNC_END = cnt_t'(H_SYNC);
    localparam cnt_t X_DISP_LO  = cnt_t'(H_SYNC + H_BACK);
    localparam cnt_t Y_SYNC_END = cnt_t'(V_SYNC);
    localparam cnt_t Y_DISP_LO  = cnt_t'(V_SYNC + V_BACK);
    localparam cnt_t Y_DISP_HI  = cnt_t'(V_SYNC + V_BACK + V_DISP);

    cnt_t x;
    cnt_t y;
    logic visible;
    logic line_active;
    cnt_t col_off;

    vga_timing_counter #(
        .H_SYNC  (H_SYNC),
        .H_BACK  (H_BACK),
        .H_DISP  (H_DISP),
        .H_FRONT (H_FRONT),
        .V_SYNC  (V_SYNC),
        .V_BACK  (V_BACK),
        .V_DISP  (V_DISP),
        .V_FRONT (V_FRONT)
    ) u_timing (
        .clk     (clk),
        .rst     (rst),
        .x       (x),
        .y       (y),
        .visible (visible)
    );

    // hSync only pulses on display lines; colour bands are 64 pixels wide.
    always_comb begin
        line_active = in_window(y, Y_DISP_LO, Y_DISP_HI);
        col_off     = x - X_DISP_LO;
        vSync       = ~in_window(y, '0, Y_SYNC_END);
        hSync       = ~(line_active && in_window(x, '0, X_SYNC_END));
        color       = visible ? 3'(col_off >> 6) : '0;
    end

endmodule

// File: tb/tb_vga_controller.sv
// Bench for vga_controller: full-size and shrunk-timing instances against an arithmetic position model.
module tb_vga_controller;

    localparam int HS_B = 8;
    localparam int HB_B = 4;
    localparam int HD_B = 200;
    localparam int HF_B = 4;
    localparam int VS_B = 2;
    localparam int VB_B = 3;
    localparam int VD_B = 6;
    localparam int VF_B = 2;
    localparam int HT_B = HS_B + HB_B + HD_B + HF_B;
    localparam int VT_B = VS_B + VB_B + VD_B + VF_B;
    localparam int FRAME_B = 2 * HT_B * VT_B;

    logic       clk;
    logic       rst_a, rst_b;
    logic [2:0] col_a, col_b;
    logic       vs_a, vs_b, hs_a, hs_b;

    int n_a = 0;
    int n_b = 0;
    int n_vec = 0;
    int n_err = 0;

    vga_controller u_dut_a (
        .clk   (clk),
        .rst   (rst_a),
        .color (col_a),
        .vSync (vs_a),
        .hSync (hs_a)
    );

    vga_controller #(
        .H_SYNC  (HS_B),
        .H_BACK  (HB_B),
        .H_DISP  (HD_B),
        .H_FRONT (HF_B),
        .V_SYNC  (VS_B),
        .V_BACK  (VB_B),
        .V_DISP  (VD_B),
        .V_FRONT (VF_B)
    ) u_dut_b (
        .clk   (clk),
        .rst   (rst_b),
        .color (col_b),
        .vSync (vs_b),
        .hSync (hs_b)
    );

    initial begin
        clk = 1'b1;
        forever #10 clk = ~clk;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Edge n after release has advanced the pixel position (n+1)/2 times.
    function automatic void model(input int n,
                                  input int hs, input int hb, input int hd, input int hf,
                                  input int vs, input int vb, input int vd, input int vf,
                                  output int eh, output int ev, output int ec);
        int p, ht, vt, x, y;
        bit ydisp;
        p  = (n + 1) / 2;
        ht = hs + hb + hd + hf;
        vt = vs + vb + vd + vf;
        x  = p % ht;
        y  = (p / ht) % vt;
        ydisp = (y >= vs + vb) && (y < vs + vb + vd);
        ev = (y < vs) ? 0 : 1;
        eh = (ydisp && x < hs) ? 0 : 1;
        ec = (ydisp && x >= hs + hb && x < hs + hb + hd) ? ((x - hs - hb) / 64) % 8 : 0;
    endfunction

    always @(posedge clk) begin
        if (rst_a) n_a = 0; else n_a = n_a + 1;
        if (rst_b) n_b = 0; else n_b = n_b + 1;
    end

    int spot_x [7] = '{144, 208, 592, 656, 143, 784, 400};
    int spot_y [7] = '{31,  31,  31,  31,  31,  31,  30};
    int spot_c [7] = '{0,   1,   7,   0,   0,   0,   0};

    logic prev_h_a = 1'b1, prev_v_a = 1'b0, prev_h_b = 1'b1, prev_v_b = 1'b0;
    bit   a_seen_vrise = 0, a_seen_hfall = 0;
    int   a_hfall_n = -1;
    bit   b_seen_vfall = 0;
    int   b_last_vfall = 0, b_last_vrise = 0, b_hcount = 0, b_hfall_n = -1;

    always @(negedge clk) begin
        int na, nb, eh, ev, ec;
        na = rst_a ? 0 : n_a;
        nb = rst_b ? 0 : n_b;

        model(na, 96, 48, 640, 16, 2, 29, 480, 10, eh, ev, ec);
        check("a_hsync", 32'(hs_a), eh);
        check("a_vsync", 32'(vs_a), ev);
        check("a_color", 32'(col_a), ec);
        model(nb, HS_B, HB_B, HD_B, HF_B, VS_B, VB_B, VD_B, VF_B, eh, ev, ec);
        check("b_hsync", 32'(hs_b), eh);
        check("b_vsync", 32'(vs_b), ev);
        check("b_color", 32'(col_b), ec);

        for (int i = 0; i < 7; i++)
            if (!rst_a && na == 2 * (spot_y[i] * 800 + spot_x[i]) - 1)
                check($sformatf("a_spot_x%0d_y%0d", spot_x[i], spot_y[i]), 32'(col_a), spot_c[i]);

        if (rst_a) begin
            a_seen_vrise = 0;
            a_seen_hfall = 0;
            a_hfall_n    = -1;
        end else begin
            if (!prev_v_a && vs_a && !a_seen_vrise) begin
                check("a_first_vsync_rise_edge", na, 3199);
                a_seen_vrise = 1;
            end
            if (prev_h_a && !hs_a) begin
                if (!a_seen_hfall) check("a_first_hsync_fall_edge", na, 49599);
                else               check("a_hsync_period", na - a_hfall_n, 1600);
                a_seen_hfall = 1;
                a_hfall_n    = na;
            end
            if (!prev_h_a && hs_a && a_hfall_n >= 0)
                check("a_hsync_low", na - a_hfall_n, 192);
        end

        if (rst_b) begin
            b_seen_vfall = 0;
            b_hcount     = 0;
            b_hfall_n    = -1;
            b_last_vrise = 0;
        end else begin
            if (prev_v_b && !vs_b) begin
                if (!b_seen_vfall) check("b_first_vsync_fall_edge", nb, FRAME_B - 1);
                else               check("b_frame_period", nb - b_last_vfall, FRAME_B);
                check("b_hsync_pulses_per_frame", b_hcount, VD_B);
                b_hcount     = 0;
                b_last_vfall = nb;
                b_seen_vfall = 1;
            end
            if (!prev_v_b && vs_b) begin
                if (b_seen_vfall) check("b_vsync_low", nb - b_last_vfall, 2 * HT_B * VS_B);
                b_last_vrise = nb;
            end
            if (prev_h_b && !hs_b) begin
                if (b_hcount == 0) check("b_vrise_to_hfall", nb - b_last_vrise, 2 * HT_B * VB_B);
                else               check("b_hsync_period", nb - b_hfall_n, 2 * HT_B);
                b_hcount++;
                b_hfall_n = nb;
            end
            if (!prev_h_b && hs_b && b_hfall_n >= 0)
                check("b_hsync_low", nb - b_hfall_n, 2 * HS_B);
        end

        prev_h_a = hs_a;
        prev_v_a = vs_a;
        prev_h_b = hs_b;
        prev_v_b = vs_b;
    end

    // Shrunk instance: three clean frames, then resets at random mid-frame points.
    initial begin
        rst_b = 1'b1;
        #25 rst_b = 1'b0;
        repeat (3 * FRAME_B + 50) @(posedge clk);
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(200, 3000)) @(posedge clk);
            #3 rst_b = 1'b1;
            #1;
            check("b_async_rst_hsync", 32'(hs_b), 1);
            check("b_async_rst_vsync", 32'(vs_b), 0);
            check("b_async_rst_color", 32'(col_b), 0);
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #5 rst_b = 1'b0;
        end
    end

    initial begin
        rst_a = 1'b1;
        #5;
        check("a_rst_hsync", 32'(hs_a), 1);
        check("a_rst_vsync", 32'(vs_a), 0);
        check("a_rst_color", 32'(col_a), 0);
        #19;
        check("a_rst_hold_hsync", 32'(hs_a), 1);
        check("a_rst_hold_vsync", 32'(vs_a), 0);
        #1 rst_a = 1'b0;

        repeat (52800 + $urandom_range(0, 400)) @(posedge clk);
        #3 rst_a = 1'b1;
        #1;
        check("a_async_rst_hsync", 32'(hs_a), 1);
        check("a_async_rst_vsync", 32'(vs_a), 0);
        check("a_async_rst_color", 32'(col_a), 0);
        repeat (3) @(posedge clk);
        #5 rst_a = 1'b0;
        repeat (4000) @(posedge clk);
        #10;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_controller.md
Name: vga_controller

Overview:
- Generates 640x480 VGA timing (hSync, vSync) and a 3-bit RGB test pattern from a 50 MHz system clock.
- Uses an internal 25 MHz pixel-enable (divide-by-2); one pixel = 2 clk cycles = 40 ns.
- Top-level display driver; outputs go straight to the VGA connector.

Parameters:
- H_SYNC, 96, hSync pulse width in pixels
- H_BACK, 48, horizontal back porch in pixels
- H_DISP, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch in pixels
- V_SYNC, 2, vSync pulse width in lines
- V_BACK, 29, vertical back porch in lines
- V_DISP, 480, visible lines per frame
- V_FRONT, 10, vertical front porch in lines

Ports:
- clk  input  1  system clock, 50 MHz, rising edge.
- rst  input  1  asynchronous, active-high reset.
- color  output  3  {R,G,B} pixel colour, 0 outside the visible area.
- vSync  output  1  vertical sync, active low.
- hSync  output  1  horizontal sync, active low.

Behaviour:
- Line = 800 pixels (32 us), ordered sync, back porch, display, front porch. Pixel index x runs 0..799: sync 0..95, back porch 96..143, display 144..783, front porch 784..799.
- Frame = 521 lines (16.672 ms), ordered sync, back porch, display, front porch. Line index y runs 0..520: sync 0..1, back porch 2..30, display 31..510, front porch 511..520.
- Divider:
  - pixEn toggles every clk edge and resets to 1, so the first rising edge after reset release advances x.
  - x increments when pixEn=1 and wraps 799->0.
  - On that wrap, y increments and wraps 520->0.
- Outputs are combinational decodes of the counter registers. They change on the same edge the counters change; there is no extra pipeline stage.
- vSync = 0 iff y < V_SYNC.
- hSync = 0 iff x < H_SYNC and y is in 31..510. hSync stays high on all non-display lines: sync, back porch and front porch.
- Colour is the top bits of the visible column: color = (x-144)[8:6] when x is in 144..783 and y is in 31..510, else 3'b000.
- Reset (asynchronous, any time, including mid-frame):
  - x=0, y=0, pixEn=1.
  - Outputs immediately hSync=1, vSync=0, color=0.
  - After release, the frame restarts at the beginning of the vSync pulse.
- Timing from reset release, counted in rising edges (edge 1 = first edge after release):
  - vSync rises at edge 3199.
  - First hSync fall is at edge 49599 (start of line 31).
  - Each hSync low lasts 192 clk; hSync period is 1600 clk.
  - Exactly 480 hSync pulses per frame.
  - vSync falls again 521*1600 clk after its previous fall.

Decomposition:
- Shared package: timing constants (H_*/V_*), derived totals H_TOTAL=800 and V_TOTAL=521, and counter widths (10 bits each).
- One sub-module is natural: vga_timing_counter (pixEn divider plus x/y counters, exporting x, y and the visible flag).
- The top level adds the sync and colour decode.

Test Plan:
- Reset held 25 ns -> hSync=1, vSync=0, color=0 throughout reset. Assert rst mid-line -> outputs return to these values asynchronously, without waiting for a clock edge.
- Release reset -> vSync rises exactly at edge 3199 (t=64000 ns with clk edges at 20 ns multiples and release at 25 ns). No hSync edge before edge 49599.
- During display lines -> hSync low for 3840 ns, high for 28160 ns, repeated 480 times. No other hSync edges occur.
- After the last display line -> vSync falls 320000 ns after the line ends and stays low for 64000 ns. The next hSync fall comes 928000 ns after vSync rises.
- Colour at line 31: x=144 -> 0, x=208 -> 1, x=592 -> 7, x=656 -> 0 (wrap). x=143 and x=784 -> 0. Any pixel on line 30 or line 511 -> 0.
- Run 3 full frames -> frame period is 833600 clk, with identical edge timing every frame.
